// File: rtl/risc_pkg.sv
// Shared constants for the VeriRisc datapath and controller: opcodes, run states, widths.
package risc_pkg;

    localparam int unsigned AWIDTH_DEF = 5;
    localparam int unsigned DWIDTH_DEF = 8;
    localparam int unsigned OPW        = 3;
    localparam int unsigned PHW        = 3;

    typedef enum logic [OPW-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } run_state_e;

endpackage

// File: rtl/risc_alu.sv
// Combinational accumulator ALU: opcode + AC + bus -> next AC value.
module risc_alu
    import risc_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF
) (
    input  logic [OPW-1:0]    i_opcode,
    input  logic [DWIDTH-1:0] i_ac,
    input  logic [DWIDTH-1:0] i_bus,
    output logic [DWIDTH-1:0] o_result
);

    // Non-arithmetic opcodes pass the accumulator through unchanged
    always_comb begin
        o_result = i_ac;
        case (i_opcode)
            OP_ADD:  o_result = i_ac + i_bus;
            OP_AND:  o_result = i_ac & i_bus;
            OP_XOR:  o_result = i_ac ^ i_bus;
            OP_LDA:  o_result = i_bus;
            default: o_result = i_ac;
        endcase
    end

endmodule

// File: rtl/risc_datapath.sv
// VeriRisc execution datapath: run FSM, phase counter, PC, IR, AC, ALU and unified memory.
module risc_datapath
    import risc_pkg::*;
#(
    parameter int unsigned AWIDTH = AWIDTH_DEF,
    parameter int unsigned DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              halt,
    input  logic              ld_pc,
    input  logic              data_e,
    input  logic              ld_ac,
    input  logic              wr,
    input  logic              start,
    input  logic              prog_we,
    input  logic [AWIDTH-1:0] prog_addr,
    input  logic [DWIDTH-1:0] prog_data,
    output logic [PHW-1:0]    phase,
    output logic [OPW-1:0]    opcode,
    output logic              zero,
    output logic              running,
    output logic              halted,
    output logic [AWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] ac,
    output logic [DWIDTH-1:0] data
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    run_state_e        r_state;
    logic [PHW-1:0]    r_phase;
    logic [AWIDTH-1:0] r_pc;
    logic [DWIDTH-1:0] r_ir;
    logic [DWIDTH-1:0] r_ac;
    logic              r_zero;
    logic              r_running;
    logic              r_halted;

    logic              w_run;
    logic [AWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_bus;
    logic [DWIDTH-1:0] w_alu;
    logic [DWIDTH-1:0] w_ac_next;

    assign w_run     = (r_state == ST_RUN);
    assign w_addr    = sel ? r_pc : r_ir[AWIDTH-1:0];
    assign w_bus     = rd ? r_mem[w_addr] : (data_e ? r_ac : '0);
    assign w_ac_next = (w_run && ld_ac) ? w_alu : r_ac;

    risc_alu #(
        .DWIDTH (DWIDTH)
    ) u_alu (
        .i_opcode (r_ir[DWIDTH-1 -: OPW]),
        .i_ac     (r_ac),
        .i_bus    (w_bus),
        .o_result (w_alu)
    );

    // Run FSM plus every architectural register; strobes only act in RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_pc      <= '0;
            r_ir      <= '0;
            r_ac      <= '0;
            r_zero    <= 1'b1;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_phase   <= '0;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (ld_ir) begin
                        r_ir <= w_bus;
                    end
                    if (ld_pc) begin
                        r_pc <= r_ir[AWIDTH-1:0];
                    end else if (inc_pc) begin
                        r_pc <= r_pc + AWIDTH'(1);
                    end
                    r_ac   <= w_ac_next;
                    r_zero <= (w_ac_next == '0);
                    // Halt freezes the phase; this cycle's PC/IR/AC updates still land
                    if (halt) begin
                        r_state   <= ST_HALT;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + PHW'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    // Memory is never cleared; machine writes in RUN, host writes otherwise
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_run && wr) begin
                r_mem[w_addr] <= w_bus;
            end else if (!w_run && prog_we) begin
                r_mem[prog_addr] <= prog_data;
            end
        end
    end

    assign phase   = r_phase;
    assign opcode  = r_ir[DWIDTH-1 -: OPW];
    assign zero    = r_zero;
    assign running = r_running;
    assign halted  = r_halted;
    assign pc      = r_pc;
    assign ac      = r_ac;
    assign data    = w_bus;

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: drives controller-style phase strobes over a known program.
module tb_risc_datapath;

    logic       clk;
    logic       rst_n;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic       start, prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [2:0] phase, opcode;
    logic       zero, running, halted;
    logic [4:0] pc;
    logic [7:0] ac, data;

    int total = 0;
    int bad   = 0;

    risc_datapath dut (
        .clk(clk), .rst_n(rst_n),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
        .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr),
        .start(start), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .phase(phase), .opcode(opcode), .zero(zero), .running(running), .halted(halted),
        .pc(pc), .ac(ac), .data(data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] instr;
        logic       skip;
        logic       finc;
        logic [4:0] exp_pc;
        logic [7:0] exp_ac;
        logic       exp_z;
    } vec_t;

    vec_t tbl [11];
    logic [4:0] pre_a [19];
    logic [7:0] pre_d [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_strobes();
        sel = 0; rd = 0; ld_ir = 0; inc_pc = 0; halt = 0;
        ld_pc = 0; data_e = 0; ld_ac = 0; wr = 0; start = 0; prog_we = 0;
    endtask

    // Strobe pattern of the VeriRisc controller for one phase
    task automatic drive_phase(input int p, input logic [7:0] instr, input logic skip, input logic finc);
        logic [2:0] op;
        logic alu, sto, jmp;
        op  = instr[7:5];
        alu = (op >= 3'd2) && (op <= 3'd5);
        sto = (op == 3'd6);
        jmp = (op == 3'd7);
        clear_strobes();
        case (p)
            0: sel = 1;
            1: begin sel = 1; rd = 1; end
            2, 3: begin sel = 1; rd = 1; ld_ir = 1; end
            4: begin sel = 1; inc_pc = 1; halt = (op == 3'd0); end
            5: rd = alu;
            6: begin rd = alu; inc_pc = skip | finc; ld_pc = jmp; data_e = sto; end
            default: begin
                rd = alu; ld_ac = alu; ld_pc = jmp; inc_pc = finc; data_e = sto; wr = sto;
            end
        endcase
    endtask

    task automatic run_instr(input logic [7:0] instr, input logic skip, input logic finc);
        for (int p = 0; p < 8; p++) begin
            drive_phase(p, instr, skip, finc);
            @(negedge clk);
        end
        clear_strobes();
    endtask

    initial begin
        pre_a = '{5'h00, 5'h01, 5'h02, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B,
                  5'h0C, 5'h0D, 5'h0E, 5'h12, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h03};
        pre_d = '{8'hA5, 8'hDF, 8'hE6, 8'h3C, 8'hA3, 8'hBE, 8'h5D, 8'h7C, 8'h20, 8'h00,
                  8'h9B, 8'h20, 8'hF2, 8'h00, 8'hFF, 8'h0F, 8'h20, 8'hF0, 8'h77};
        //            instr  skip  finc  pc     ac     z
        tbl[0]  = '{8'hA5, 1'b0, 1'b0, 5'h01, 8'h3C, 1'b0};  // LDA 5
        tbl[1]  = '{8'hDF, 1'b0, 1'b0, 5'h02, 8'h3C, 1'b0};  // STO 1F
        tbl[2]  = '{8'hE6, 1'b0, 1'b1, 5'h06, 8'h3C, 1'b0};  // JMP 6 with inc_pc forced
        tbl[3]  = '{8'hA3, 1'b0, 1'b0, 5'h07, 8'h77, 1'b0};  // LDA 3 (host-written)
        tbl[4]  = '{8'hBE, 1'b0, 1'b0, 5'h08, 8'hF0, 1'b0};  // LDA 1E
        tbl[5]  = '{8'h5D, 1'b0, 1'b0, 5'h09, 8'h10, 1'b0};  // ADD 1D wraps
        tbl[6]  = '{8'h7C, 1'b0, 1'b0, 5'h0A, 8'h00, 1'b1};  // AND 1C -> zero
        tbl[7]  = '{8'h20, 1'b1, 1'b0, 5'h0C, 8'h00, 1'b1};  // SKZ taken
        tbl[8]  = '{8'h9B, 1'b0, 1'b0, 5'h0D, 8'hFF, 1'b0};  // XOR 1B
        tbl[9]  = '{8'h20, 1'b0, 1'b0, 5'h0E, 8'hFF, 1'b0};  // SKZ not taken
        tbl[10] = '{8'hF2, 1'b0, 1'b1, 5'h12, 8'hFF, 1'b0};  // JMP 12 with inc_pc forced

        clear_strobes();
        prog_addr = '0;
        prog_data = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;

        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_ac", 32'(ac), 32'h00);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_zero", 32'(zero), 32'h1);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        // Host preload while idle
        for (int i = 0; i < 19; i++) begin
            prog_we = 1; prog_addr = pre_a[i]; prog_data = pre_d[i];
            @(negedge clk);
        end
        prog_we = 0;

        start = 1;
        @(negedge clk);
        start = 0;
        chk("start_running", 32'(running), 32'h1);
        chk("start_phase", 32'(phase), 32'h0);
        chk("start_pc", 32'(pc), 32'h00);
        @(posedge clk);
        @(negedge clk);
        chk("start_phase_adv", 32'(phase), 32'h1);
        // Realign: the extra cycle ran phase 0 with no strobes; finish that instruction slot
        for (int p = 1; p < 8; p++) @(negedge clk);
        chk("realign_phase", 32'(phase), 32'h0);

        for (int i = 0; i < 11; i++) begin
            run_instr(tbl[i].instr, tbl[i].skip, tbl[i].finc);
            chk($sformatf("row%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
            chk($sformatf("row%0d_ac", i), 32'(ac), 32'(tbl[i].exp_ac));
            chk($sformatf("row%0d_zero", i), 32'(zero), 32'(tbl[i].exp_z));
            chk($sformatf("row%0d_opcode", i), 32'(opcode), 32'(tbl[i].instr[7:5]));
            chk($sformatf("row%0d_phase", i), 32'(phase), 32'h0);
        end

        // HLT at 0x12
        run_instr(8'h00, 1'b0, 1'b0);
        chk("hlt_halted", 32'(halted), 32'h1);
        chk("hlt_running", 32'(running), 32'h0);
        chk("hlt_pc", 32'(pc), 32'h13);
        chk("hlt_phase", 32'(phase), 32'h4);
        chk("hlt_ac", 32'(ac), 32'hFF);

        // Strobes while halted: write AC to mem[0] would corrupt LDA 5 later
        sel = 0; data_e = 1; wr = 1; inc_pc = 1; ld_ac = 1; ld_pc = 1;
        prog_we = 1; prog_addr = 5'h13; prog_data = 8'hFF;   // JMP 1F
        @(negedge clk);
        prog_we = 0;
        @(negedge clk);
        clear_strobes();
        chk("halt_hold_pc", 32'(pc), 32'h13);
        chk("halt_hold_ac", 32'(ac), 32'hFF);
        chk("halt_hold_phase", 32'(phase), 32'h4);

        start = 1;
        @(negedge clk);
        start = 0;
        chk("resume_running", 32'(running), 32'h1);
        chk("resume_halted", 32'(halted), 32'h0);
        chk("resume_phase", 32'(phase), 32'h0);
        chk("resume_pc", 32'(pc), 32'h13);

        // JMP 1F (host-written in HALT) with a host write attempt during RUN
        for (int p = 0; p < 8; p++) begin
            drive_phase(p, 8'hFF, 1'b0, 1'b0);
            prog_we = 1; prog_addr = 5'h05; prog_data = 8'h99;
            @(negedge clk);
        end
        clear_strobes();
        chk("jmp1f_pc", 32'(pc), 32'h1F);

        // mem[1F] holds 0x3C from STO: SKZ, zero clear, PC wraps 1F -> 00
        run_instr(8'h3C, 1'b0, 1'b0);
        chk("wrap_pc", 32'(pc), 32'h00);
        chk("sto_opcode", 32'(opcode), 32'h1);

        run_instr(8'hA5, 1'b0, 1'b0);
        chk("lda_after_halt_ac", 32'(ac), 32'h3C);
        chk("lda_after_halt_pc", 32'(pc), 32'h01);

        // Reset in the middle of STO at phase 5 with rd asserted
        for (int p = 0; p < 5; p++) begin
            drive_phase(p, 8'hDF, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive_phase(5, 8'hDF, 1'b0, 1'b0);
        rd = 1; ld_ac = 1; start = 1;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        clear_strobes();
        chk("mid_rst_pc", 32'(pc), 32'h00);
        chk("mid_rst_ac", 32'(ac), 32'h00);
        chk("mid_rst_phase", 32'(phase), 32'h0);
        chk("mid_rst_opcode", 32'(opcode), 32'h0);
        chk("mid_rst_zero", 32'(zero), 32'h1);
        chk("mid_rst_running", 32'(running), 32'h0);
        chk("mid_rst_halted", 32'(halted), 32'h0);

        // Idle bus reads; strobes ignored while idle
        sel = 1; rd = 1; inc_pc = 1;
        #1 chk("idle_bus_rd", 32'(data), 32'hA5);
        data_e = 1;
        #1 chk("idle_bus_rd_wins", 32'(data), 32'hA5);
        @(negedge clk);
        clear_strobes();
        chk("idle_pc_hold", 32'(pc), 32'h00);

        start = 1;
        @(negedge clk);
        start = 0;
        run_instr(8'hA5, 1'b0, 1'b0);
        chk("post_rst_ac", 32'(ac), 32'h3C);
        chk("post_rst_pc", 32'(pc), 32'h01);
        chk("post_rst_zero", 32'(zero), 32'h0);
        chk("post_rst_phase", 32'(phase), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
